// File: rtl/cache_mem_pkg.sv
// Shared definitions for the cache backing-memory responder.
// Holds the FSM state encoding, the default geometry and init pattern,
// and a width helper that never returns zero so counters always elaborate.
package cache_mem_pkg;

    typedef enum logic [2:0] {
        ST_INIT = 3'd0,
        ST_IDLE = 3'd1,
        ST_WAIT = 3'd2,
        ST_XFER = 3'd3,
        ST_WACK = 3'd4
    } state_e;

    localparam int DEF_ADDR_W     = 7;
    localparam int DEF_DATA_W     = 8;
    localparam int DEF_LATENCY    = 3;
    localparam int DEF_LINE_WORDS = 4;
    localparam int LINE_OFF_W     = $clog2(DEF_LINE_WORDS);
    localparam logic [7:0] DEF_INIT_XOR = 8'hA5;

    // Bit width needed to count 0..n-1, at least one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cache_backing_mem_responder_if.sv
// Request/response bus between the cache controller (master) and the
// backing-memory responder (slave).
//   mem_req/mem_we/mem_addr/mem_wdata : request from the cache
//   mem_req_ready                     : responder can accept this cycle
//   mem_rvalid/mem_rdata/mem_rlast    : line-fill read beats, no backpressure
//   mem_wack                          : one-cycle write-complete pulse
//   busy                              : store initialisation in progress
interface cache_backing_mem_responder_if #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 8
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_req_ready;
    logic              mem_rvalid;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_rlast;
    logic              mem_wack;
    logic              busy;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_req_ready, mem_rvalid, mem_rdata, mem_rlast, mem_wack, busy
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_req_ready, mem_rvalid, mem_rdata, mem_rlast, mem_wack, busy
    );
endinterface

// File: rtl/cache_mem_array.sv
// Backing store: 2**ADDR_W words of DATA_W bits.
// One synchronous write port, one asynchronous read port; contents are not
// reset (the responder rewrites every word after each reset).
//   clk      : write clock
//   we_i     : write enable
//   waddr_i  : write address
//   wdata_i  : write data
//   raddr_i  : read address
//   rdata_o  : read data (combinational)
module cache_mem_array #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);
    logic [DATA_W-1:0] mem_q [2**ADDR_W];

    // Storage write port.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/cache_backing_mem_responder.sv
// Memory-side responder for the cache controller's miss/write-through port.
// After reset it sweeps the whole store with mem[a] = a ^ INIT_XOR, then
// accepts one request at a time in IDLE:
//   write : store word immediately, pulse mem_wack LATENCY+1 cycles later
//   read  : after LATENCY wait cycles, stream LINE_WORDS beats of the line,
//           critical word first, wrapping inside the line
// Ports: clk, rst_n (async active-low), bus (slave side of the
// cache_backing_mem_responder_if bus). All bus outputs are registered.
module cache_backing_mem_responder
    import cache_mem_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int LATENCY    = DEF_LATENCY,
    parameter int LINE_WORDS = DEF_LINE_WORDS,
    parameter logic [DATA_W-1:0] INIT_XOR = DATA_W'(DEF_INIT_XOR)
) (
    input  logic clk,
    input  logic rst_n,
    cache_backing_mem_responder_if.slave bus
);
    localparam int BEAT_W = cnt_w(LINE_WORDS);
    localparam int WCNT_W = cnt_w(LATENCY + 1);
    localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(LINE_WORDS - 1);
    localparam logic [ADDR_W-1:0] PTR_LAST = {ADDR_W{1'b1}};
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(LINE_WORDS - 1);

    if (LATENCY < 1) begin : g_bad_latency
        $error("cache_backing_mem_responder: LATENCY must be >= 1");
    end
    if ((LINE_WORDS < 1) || ((LINE_WORDS & (LINE_WORDS - 1)) != 0)) begin : g_bad_line
        $error("cache_backing_mem_responder: LINE_WORDS must be a power of two");
    end
    if (LINE_WORDS > (2 ** ADDR_W)) begin : g_big_line
        $error("cache_backing_mem_responder: LINE_WORDS exceeds store depth");
    end

    state_e             state_q;
    logic [ADDR_W-1:0]  ptr_q;
    logic [ADDR_W-1:0]  base_q;
    logic [ADDR_W-1:0]  off_q;
    logic [BEAT_W-1:0]  beat_q;
    logic [WCNT_W-1:0]  wcnt_q;
    logic               is_wr_q;
    logic               ready_q;
    logic               rvalid_q;
    logic [DATA_W-1:0]  rdata_q;
    logic               rlast_q;
    logic               wack_q;
    logic               busy_q;

    logic               accept_s;
    logic               arr_we_s;
    logic [ADDR_W-1:0]  arr_waddr_s;
    logic [DATA_W-1:0]  arr_wdata_s;
    logic [ADDR_W-1:0]  rd_addr_s;
    logic [DATA_W-1:0]  rd_data_s;

    assign accept_s = (state_q == ST_IDLE) && bus.mem_req;

    // Beat address: offset advances modulo the line, base keeps us inside it.
    assign rd_addr_s = base_q | ((off_q + ADDR_W'(beat_q)) & OFF_MASK);

    // Write-port mux: init sweep owns the port during INIT, requests otherwise.
    always_comb begin
        arr_we_s    = 1'b0;
        arr_waddr_s = bus.mem_addr;
        arr_wdata_s = bus.mem_wdata;
        if (state_q == ST_INIT) begin
            arr_we_s    = 1'b1;
            arr_waddr_s = ptr_q;
            arr_wdata_s = DATA_W'(ptr_q) ^ INIT_XOR;
        end else begin
            arr_we_s    = accept_s && bus.mem_we;
            arr_waddr_s = bus.mem_addr;
            arr_wdata_s = bus.mem_wdata;
        end
    end

    cache_mem_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_array (
        .clk     (clk),
        .we_i    (arr_we_s),
        .waddr_i (arr_waddr_s),
        .wdata_i (arr_wdata_s),
        .raddr_i (rd_addr_s),
        .rdata_o (rd_data_s)
    );

    // Control FSM with wait/beat counters and registered bus outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_INIT;
            ptr_q    <= '0;
            base_q   <= '0;
            off_q    <= '0;
            beat_q   <= '0;
            wcnt_q   <= '0;
            is_wr_q  <= 1'b0;
            ready_q  <= 1'b0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            rlast_q  <= 1'b0;
            wack_q   <= 1'b0;
            busy_q   <= 1'b1;
        end else begin
            case (state_q)
                ST_INIT: begin
                    if (ptr_q == PTR_LAST) begin
                        state_q <= ST_IDLE;
                        ptr_q   <= '0;
                        busy_q  <= 1'b0;
                        ready_q <= 1'b1;
                    end else begin
                        ptr_q   <= ptr_q + ADDR_W'(1);
                    end
                end
                ST_IDLE: begin
                    if (accept_s) begin
                        state_q <= ST_WAIT;
                        ready_q <= 1'b0;
                        is_wr_q <= bus.mem_we;
                        base_q  <= bus.mem_addr & ~OFF_MASK;
                        off_q   <= bus.mem_addr & OFF_MASK;
                        beat_q  <= '0;
                        wcnt_q  <= WCNT_W'(LATENCY - 1);
                    end else begin
                        ready_q <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (wcnt_q == '0) begin
                        if (is_wr_q) begin
                            state_q <= ST_WACK;
                            wack_q  <= 1'b1;
                        end else begin
                            // First beat is the critical word (beat_q is 0 here).
                            state_q  <= ST_XFER;
                            rvalid_q <= 1'b1;
                            rdata_q  <= rd_data_s;
                            rlast_q  <= (beat_q == BEAT_LAST);
                            beat_q   <= beat_q + BEAT_W'(1);
                        end
                    end else begin
                        wcnt_q <= wcnt_q - WCNT_W'(1);
                    end
                end
                ST_XFER: begin
                    if (rlast_q) begin
                        state_q  <= ST_IDLE;
                        rvalid_q <= 1'b0;
                        rdata_q  <= '0;
                        rlast_q  <= 1'b0;
                        ready_q  <= 1'b1;
                    end else begin
                        rdata_q  <= rd_data_s;
                        rlast_q  <= (beat_q == BEAT_LAST);
                        beat_q   <= beat_q + BEAT_W'(1);
                    end
                end
                ST_WACK: begin
                    state_q <= ST_IDLE;
                    wack_q  <= 1'b0;
                    ready_q <= 1'b1;
                end
                default: begin
                    // Unreachable encoding: recover by re-initialising the store.
                    state_q  <= ST_INIT;
                    ptr_q    <= '0;
                    ready_q  <= 1'b0;
                    rvalid_q <= 1'b0;
                    rdata_q  <= '0;
                    rlast_q  <= 1'b0;
                    wack_q   <= 1'b0;
                    busy_q   <= 1'b1;
                end
            endcase
        end
    end

    assign bus.mem_req_ready = ready_q;
    assign bus.mem_rvalid    = rvalid_q;
    assign bus.mem_rdata     = rdata_q;
    assign bus.mem_rlast     = rlast_q;
    assign bus.mem_wack      = wack_q;
    assign bus.busy          = busy_q;
endmodule
